// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//   Program counter. It can increment, jump and (optionally) call and return
//   through a small LIFO return stack. One operation runs per rising edge,
//   chosen in this priority order:
//     ret > call > load > inc > hold
//   A request that loses arbitration is dropped, not held over.
//
// Configuration macro:
//   PC_RET_STACK_EN  defined   -> the return stack is built, with stack flags
//                                 and the sticky error flag.
//                    undefined -> there is no stack. call_en acts as a jump,
//                                 ret_en and clr_err are ignored, and the
//                                 flags are tied to full=0, empty=1, err=0.
//
// Parameters:
//   WIDTH      counter / address width in bits (>= 2)
//   DEPTH      number of return-stack entries (>= 1)
//   RESET_VAL  value loaded into count on reset
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   reset      asynchronous reset, active low
//   inc_en     count <= count + 1 (wraps modulo 2^WIDTH)
//   load_en    jump: count <= load_val
//   load_val   target for a jump or call
//   call_en    push count+1, then count <= load_val
//   ret_en     pop the top of the stack into count
//   clr_err    synchronous clear of stk_err (an error on the same edge wins)
//   count      current program counter (registered)
//   stk_full   stack holds DEPTH entries (registered)
//   stk_empty  stack holds 0 entries (registered)
//   stk_err    sticky flag for overflow or underflow (registered)
//   wrap       one-cycle pulse after an increment from all-ones to zero
// -----------------------------------------------------------------------------
module prog_counter #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err,
  output logic             wrap
);

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

`ifdef PC_RET_STACK_EN

  // The occupancy counter must be able to hold 0..DEPTH inclusive.
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             full_d;
  logic             empty_d;
  logic             err_d;
  logic             push;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  // Entry i sits on top of the stack when occupancy equals i+1.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (OCC_W'(i + 1) == occ_q) top_val = stack_mem[i];
    end
  end

  assign push_val = count + WIDTH'(1);

  // NOTE: every signal written here gets a default first. A path that
  //       leaves a signal unassigned would infer a latch.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    occ_d   = occ_q;
    err_d   = stk_err;
    push    = 1'b0;

    // The clear is applied first so that an error raised later on the
    // same edge overrides it.
    if (clr_err) err_d = 1'b0;

    if (ret_en) begin
      // A call on the same edge is discarded completely.
      if (occ_q != '0) begin
        count_d = top_val;
        occ_d   = occ_q - OCC_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (call_en) begin
      if (occ_q != OCC_W'(DEPTH)) begin
        push    = 1'b1;
        count_d = load_val;
        occ_d   = occ_q + OCC_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (load_en) begin
      count_d = load_val;
    end else if (inc_en) begin
      count_d = count + WIDTH'(1);
      wrap_d  = &count;
    end

    full_d  = (occ_d == OCC_W'(DEPTH));
    empty_d = (occ_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments. All flops then
  //       update together from values sampled before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= WIDTH'(RESET_VAL);
      wrap      <= 1'b0;
      occ_q     <= '0;
      stk_full  <= 1'b0;
      stk_empty <= 1'b1;
      stk_err   <= 1'b0;
    end else begin
      count     <= count_d;
      wrap      <= wrap_d;
      occ_q     <= occ_d;
      stk_full  <= full_d;
      stk_empty <= empty_d;
      stk_err   <= err_d;
    end
  end

  // NOTE: the stack storage has no reset. An entry is only read after it has
  //       been pushed, so its contents while empty do not matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (OCC_W'(i) == occ_q)) stack_mem[i] <= push_val;
    end
  end

`else

  // Without the stack a call is just a jump. ret_en and clr_err have no effect.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (call_en || load_en) begin
      count_d = load_val;
    end else if (inc_en) begin
      count_d = count + WIDTH'(1);
      wrap_d  = &count;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= WIDTH'(RESET_VAL);
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_err   = 1'b0;

  logic unused_stack_inputs;
  assign unused_stack_inputs = &{1'b0, ret_en, clr_err};

`endif

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter/address width in bits (>=2).
REQ-002 Parameter DEPTH, default 4, return-stack entries (>=1).
REQ-003 Parameter RESET_VAL, default 0, count value loaded on reset.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 inc_en  in  1  increment count by 1.
REQ-007 load_en  in  1  jump: count <= load_val.
REQ-008 load_val  in  WIDTH  jump/call target.
REQ-009 call_en  in  1  push count+1, then count <= load_val.
REQ-010 ret_en  in  1  pop top of stack into count.
REQ-011 clr_err  in  1  synchronous clear of stk_err.
REQ-012 count  out  WIDTH  current program counter, registered.
REQ-013 stk_full  out  1  stack holds DEPTH entries.
REQ-014 stk_empty  out  1  stack holds 0 entries.
REQ-015 stk_err  out  1  sticky overflow/underflow flag.
REQ-016 wrap  out  1  one-cycle pulse after increment wrap-around.

Function
REQ-017 Per edge, exactly one operation SHALL execute, priority ret_en > call_en > load_en > inc_en > hold.
REQ-018 Increment SHALL be modulo 2^WIDTH; all-ones + 1 = 0.
REQ-019 wrap SHALL be 1 for exactly the cycle following an edge where increment took count from all-ones to 0; load/call/ret reaching 0 SHALL NOT assert wrap.
REQ-020 Call, stack not full: push (count+1) mod 2^WIDTH, count <= load_val, occupancy +1; same edge.
REQ-021 Call, stack full: no push, count holds, stk_err <= 1.
REQ-022 Ret, stack not empty: count <= top entry, occupancy -1; same edge.
REQ-023 Ret, stack empty: count holds, stk_err <= 1.
REQ-024 call_en and ret_en together: ret executes, call discarded (no push, no jump, no error from call).
REQ-025 Lower-priority requests in the same cycle SHALL be discarded, not deferred.
REQ-026 stk_full/stk_empty SHALL be registered-state decodes of occupancy, valid the cycle after the changing edge.
REQ-027 clr_err SHALL clear stk_err on the edge; if an error event occurs on the same edge, stk_err SHALL be 1 (set wins).
REQ-028 Stack SHALL be LIFO; occupancy counter width SHALL hold 0..DEPTH inclusive.
REQ-029 All outputs SHALL be driven directly from flops; no combinational input-to-output paths.

Reset
REQ-030 reset=0 SHALL immediately, without clk, force count=RESET_VAL, occupancy=0, stk_empty=1, stk_full=0, stk_err=0, wrap=0.
REQ-031 Stack storage contents need not be reset; they are unreadable while empty.
REQ-032 Reset asserted mid-call/ret SHALL abort the operation; state after release equals REQ-030.
REQ-033 First operation SHALL occur on the first rising clk edge after reset returns to 1.

Configuration
REQ-034 Macro PC_RET_STACK_EN defined: return stack and REQ-020..REQ-024, REQ-027 implemented as above.
REQ-035 Macro undefined: no stack storage; call_en behaves as load_en (jump, no push); ret_en ignored; stk_full=0, stk_empty=1, stk_err=0 constant; clr_err unused; priority call/load > inc.

Verification (WIDTH=4, DEPTH=2, RESET_VAL=0, macro defined unless stated)
REQ-036 Count to 7, drive reset=0 mid-cycle -> count=0 before next clk edge; stays 0 while reset=0.
REQ-037 inc_en=1 for 16 edges from 0 -> count 1..15 then 0; wrap=1 only the cycle count first reads 0.
REQ-038 count=3, call_en with load_val=9 -> count=9, stk_empty=0; then ret_en -> count=4, stk_empty=1.
REQ-039 Two calls -> stk_full=1; third call (load_val=5) -> count unchanged, stk_err=1; clr_err -> stk_err=0.
REQ-040 Empty stack, count=6, ret_en -> count=6, stk_err=1; ret_en+inc_en together -> inc discarded.
REQ-041 One entry (value 4), call_en+ret_en same edge -> count=4, stack empty, stk_err=0; rerun with macro undefined: call_en load_val=9 -> count=9, stk_empty stays 1.
